// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stall-bus patterns
// and the controller state encoding.
package hazard_ctrl_pkg;

  localparam int unsigned STALL_W = 6;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Stall-bus patterns, bit k holds stage k: [0] PC .. [5] WB
  localparam logic [STALL_W-1:0] STALL_NONE    = '0;
  localparam logic [STALL_W-1:0] STALL_LOADUSE = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX      = 6'b001111;

  typedef enum logic [1:0] {
    HC_IDLE = 2'd0,
    HC_BUSY = 2'd1,
    HC_DONE = 2'd2
  } hc_state_e;

endpackage

// File: rtl/hazard_ctrl_md_lat_counter.sv
// md_lat_counter: loadable 6-bit down-counter that flags a value of one.
// Load has priority over decrement; decrement stops at zero.
module md_lat_counter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [5:0] i_load_val,
  input  logic       i_dec,
  output logic       o_is_one
);

  logic [5:0] r_cnt;

  // Latency count register: load on start, count down while busy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 6'd1;
    end
  end

  assign o_is_one = (r_cnt == 6'd1);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall controller. Merges the ID load-use request with
// EX multiply/divide occupancy into the stall bus, sequences mul/div latency,
// and counts cycles in which the PC is held (saturating).
// Optional build macro HAZARD_CTRL_EXT_DIV_DONE_EN: divides finish on div_ready
// instead of the fixed DIV_LAT count.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               ex_md_start,
  input  logic               ex_md_is_div,
  input  logic               div_ready,
  output logic [STALL_W-1:0] stall,
  output logic               md_done,
  output logic               md_busy,
  output logic [31:0]        stall_cycles
);

  localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

  hc_state_e   r_state;
  hc_state_e   w_state_nx;
  logic        r_is_div;
  logic [31:0] r_stall_cycles;
  logic        w_load;
  logic        w_dec;
  logic        w_cnt_one;
  logic        w_busy_exit;

  md_lat_counter u_cnt (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_load_val (ex_md_is_div ? DIV_LOAD : MUL_LOAD),
    .i_dec      (w_dec),
    .o_is_one   (w_cnt_one)
  );

`ifdef HAZARD_CTRL_EXT_DIV_DONE_EN
  assign w_busy_exit = r_is_div ? div_ready : w_cnt_one;
`else
  logic w_unused;
  assign w_unused    = ^{div_ready, r_is_div};
  assign w_busy_exit = w_cnt_one;
`endif

  // State register and operation-type latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= HC_IDLE;
      r_is_div <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_load) begin
        r_is_div <= ex_md_is_div;
      end
    end
  end

  // Next-state and stall-bus selection; EX hold masks the load-use request
  always_comb begin
    w_state_nx = r_state;
    stall      = STALL_NONE;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    unique case (r_state)
      HC_IDLE: begin
        if (ex_md_start) begin
          stall      = STALL_EX;
          w_load     = 1'b1;
          w_state_nx = HC_BUSY;
        end else if (stallreq_id) begin
          stall = STALL_LOADUSE;
        end
      end
      HC_BUSY: begin
        stall = STALL_EX;
        w_dec = 1'b1;
        if (w_busy_exit) begin
          w_state_nx = HC_DONE;
        end
      end
      HC_DONE: begin
        stall      = stallreq_id ? STALL_LOADUSE : STALL_NONE;
        w_state_nx = HC_IDLE;
      end
      default: begin
        w_state_nx = HC_IDLE;
      end
    endcase
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if ((stall[0] == STOP) && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign md_busy      = (r_state == HC_BUSY);
  assign md_done      = (r_state == HC_DONE);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MUL_LAT=4, DIV_LAT=33).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        ex_md_start = 1'b0;
  logic        ex_md_is_div = 1'b0;
  logic        div_ready = 1'b0;
  logic [5:0]  stall;
  logic        md_done;
  logic        md_busy;
  logic [31:0] stall_cycles;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_LU   = 6'b000111;
  localparam logic [5:0] P_EX   = 6'b001111;

  hazard_ctrl #(
    .MUL_LAT (4),
    .DIV_LAT (33)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_md_start  (ex_md_start),
    .ex_md_is_div (ex_md_is_div),
    .div_ready    (div_ready),
    .stall        (stall),
    .md_done      (md_done),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_stall", 32'(stall), 32'(P_NONE));
    chk("rst_done", 32'(md_done), 32'd0);
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_sc", stall_cycles, 32'd0);
    cyc(); rst = 1'b0;
    cyc(); #1 chk("idle_stall", 32'(stall), 32'(P_NONE));

    // Load-use bubble, one cycle
    cyc(); stallreq_id = 1'b1;
    #1 chk("lu_stall", 32'(stall), 32'(P_LU));
    chk("lu_busy", 32'(md_busy), 32'd0);
    cyc(); stallreq_id = 1'b0;
    #1 chk("lu_after", 32'(stall), 32'(P_NONE));
    chk("lu_sc", stall_cycles, 32'd1);

    // Multiply: 4 stalled cycles, done in the 5th
    cyc(); ex_md_start = 1'b1; ex_md_is_div = 1'b0;
    #1 chk("mul_c0_stall", 32'(stall), 32'(P_EX));
    chk("mul_c0_busy", 32'(md_busy), 32'd0);
    for (int i = 1; i < 4; i++) begin
      cyc(); ex_md_start = 1'b0;
      #1 chk($sformatf("mul_c%0d_stall", i), 32'(stall), 32'(P_EX));
      chk($sformatf("mul_c%0d_busy", i), 32'(md_busy), 32'd1);
      chk($sformatf("mul_c%0d_done", i), 32'(md_done), 32'd0);
    end
    cyc(); #1 chk("mul_c4_stall", 32'(stall), 32'(P_NONE));
    chk("mul_c4_done", 32'(md_done), 32'd1);
    chk("mul_c4_busy", 32'(md_busy), 32'd0);
    chk("mul_c4_sc", stall_cycles, 32'd5);
    cyc(); #1 chk("mul_c5_done", 32'(md_done), 32'd0);
    chk("mul_c5_busy", 32'(md_busy), 32'd0);

    // Start pulse while BUSY is ignored
    cyc(); ex_md_start = 1'b1; ex_md_is_div = 1'b0;
    #1 chk("sb_c0_stall", 32'(stall), 32'(P_EX));
    cyc(); ex_md_start = 1'b0;
    #1 chk("sb_c1_stall", 32'(stall), 32'(P_EX));
    cyc(); ex_md_start = 1'b1; ex_md_is_div = 1'b1;
    #1 chk("sb_c2_stall", 32'(stall), 32'(P_EX));
    chk("sb_c2_busy", 32'(md_busy), 32'd1);
    cyc(); ex_md_start = 1'b0; ex_md_is_div = 1'b0;
    #1 chk("sb_c3_stall", 32'(stall), 32'(P_EX));
    cyc(); #1 chk("sb_c4_done", 32'(md_done), 32'd1);
    chk("sb_c4_stall", 32'(stall), 32'(P_NONE));
    cyc(); #1 chk("sb_c5_done", 32'(md_done), 32'd0);
    chk("sb_c5_busy", 32'(md_busy), 32'd0);
    chk("sb_c5_sc", stall_cycles, 32'd9);
    cyc(); #1 chk("sb_c6_done", 32'(md_done), 32'd0);
    chk("sb_c6_busy", 32'(md_busy), 32'd0);

`ifdef HAZARD_CTRL_EXT_DIV_DONE_EN
    // Divide completes on external div_ready
    cyc(); ex_md_start = 1'b1; ex_md_is_div = 1'b1;
    #1 chk("xd_c0_stall", 32'(stall), 32'(P_EX));
    for (int i = 1; i < 8; i++) begin
      cyc(); ex_md_start = 1'b0; ex_md_is_div = 1'b0;
      div_ready = (i == 7);
      #1 chk($sformatf("xd_c%0d_stall", i), 32'(stall), 32'(P_EX));
      chk($sformatf("xd_c%0d_done", i), 32'(md_done), 32'd0);
    end
    cyc(); div_ready = 1'b0;
    #1 chk("xd_c8_done", 32'(md_done), 32'd1);
    chk("xd_c8_stall", 32'(stall), 32'(P_NONE));
    chk("xd_c8_sc", stall_cycles, 32'd17);
    cyc(); #1 chk("xd_c9_busy", 32'(md_busy), 32'd0);
`else
    // Divide with load-use request held: EX pattern wins for 33 cycles
    cyc(); stallreq_id = 1'b1; ex_md_start = 1'b1; ex_md_is_div = 1'b1;
    #1 chk("dv_c0_stall", 32'(stall), 32'(P_EX));
    for (int i = 1; i < 33; i++) begin
      cyc(); ex_md_start = 1'b0; ex_md_is_div = 1'b0;
      #1 chk($sformatf("dv_c%0d_stall", i), 32'(stall), 32'(P_EX));
    end
    cyc(); #1 chk("dv_c33_stall", 32'(stall), 32'(P_LU));
    chk("dv_c33_done", 32'(md_done), 32'd1);
    cyc(); #1 chk("dv_c34_stall", 32'(stall), 32'(P_LU));
    chk("dv_c34_done", 32'(md_done), 32'd0);
    chk("dv_c34_busy", 32'(md_busy), 32'd0);
    cyc(); stallreq_id = 1'b0;
    #1 chk("dv_c35_stall", 32'(stall), 32'(P_NONE));
    chk("dv_c35_sc", stall_cycles, 32'd44);
`endif

    // Asynchronous reset mid-divide (counter at 10 in cycle 23)
    cyc(); ex_md_start = 1'b1; ex_md_is_div = 1'b1;
    #1 chk("rb_c0_stall", 32'(stall), 32'(P_EX));
    for (int i = 1; i < 24; i++) begin
      cyc(); ex_md_start = 1'b0; ex_md_is_div = 1'b0;
    end
    #1 chk("rb_pre_busy", 32'(md_busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rb_stall", 32'(stall), 32'(P_NONE));
    chk("rb_done", 32'(md_done), 32'd0);
    chk("rb_busy", 32'(md_busy), 32'd0);
    chk("rb_sc", stall_cycles, 32'd0);
    cyc(); rst = 1'b0;
    #1 chk("rb_rel_stall", 32'(stall), 32'(P_NONE));
    chk("rb_rel_busy", 32'(md_busy), 32'd0);
    cyc(); #1 chk("rb_idle_busy", 32'(md_busy), 32'd0);
    chk("rb_idle_done", 32'(md_done), 32'd0);
    chk("rb_idle_sc", stall_cycles, 32'd0);

    // Fresh multiply after reset still works
    cyc(); ex_md_start = 1'b1;
    #1 chk("pm_c0_stall", 32'(stall), 32'(P_EX));
    cyc(); ex_md_start = 1'b0;
    cyc(); cyc(); cyc();
    #1 chk("pm_c4_done", 32'(md_done), 32'd1);
    chk("pm_c4_sc", stall_cycles, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
